// File: rtl/issue_queue_pkg.sv
// Shared types and sizing for the decode-to-dispatch instruction queue.
// PC_set is the decoded instruction bundle passed between pipeline stages.
package issue_queue_pkg;

    localparam int IQ_DEPTH = 8;
    localparam int IQ_PTR_W = $clog2(IQ_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        o_valid;
    } PC_set;

endpackage

// File: rtl/issue_queue_if.sv
// Handshake bundle between decode/dispatch (master) and the issue queue (slave).
interface issue_queue_if;
    import issue_queue_pkg::*;

    logic        flush;
    logic        stall;
    PC_set       i_set1;
    PC_set       i_set2;
    logic [1:0]  i_valid;
    logic        o_full;
    logic [1:0]  i_usingNUM;
    PC_set       o_set1;
    PC_set       o_set2;
    logic [1:0]  o_is_valid;

    modport master (
        output flush, stall, i_set1, i_set2, i_valid, i_usingNUM,
        input  o_full, o_set1, o_set2, o_is_valid
    );

    modport slave (
        input  flush, stall, i_set1, i_set2, i_valid, i_usingNUM,
        output o_full, o_set1, o_set2, o_is_valid
    );

endinterface

// File: rtl/issue_queue.sv
// Dual-write, dual-read circular buffer decoupling decode from issue dispatch.
// Pushes are all-or-nothing against a registered full flag; pops are clamped to occupancy.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic         clk,
    input  logic         rstn,
    issue_queue_if.slave iq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    PC_set          mem [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  count;
    logic [1:0]     wr_n;
    logic [1:0]     rd_n;
    logic           full;
    PC_set          first_set;

    // Full looks only at registered count so decode's hold signal stays off the pop path.
    assign full = (count > CW'(DEPTH - 2));

    always_comb begin
        wr_n      = 2'd0;
        first_set = iq.i_valid[1] ? iq.i_set1 : iq.i_set2;
        if (!full) begin
            wr_n = {1'b0, iq.i_valid[1]} + {1'b0, iq.i_valid[0]};
        end
    end

    always_comb begin
        rd_n = 2'd0;
        if (!iq.stall && (iq.i_usingNUM != 2'd3)) begin
            if (CW'(iq.i_usingNUM) > count) begin
                rd_n = count[1:0];
            end else begin
                rd_n = iq.i_usingNUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (iq.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(rd_n);
            tail  <= tail + PW'(wr_n);
            count <= count + CW'(wr_n) - CW'(rd_n);
        end
    end

    // Storage is deliberately left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!iq.flush && (wr_n != 2'd0)) begin
            mem[tail] <= first_set;
            if (wr_n == 2'd2) begin
                mem[tail + PW'(1)] <= iq.i_set2;
            end
        end
    end

    always_comb begin
        iq.o_set1         = mem[head];
        iq.o_set2         = mem[head + PW'(1)];
        iq.o_is_valid     = {(count >= CW'(1)), (count >= CW'(2))};
        iq.o_set1.o_valid = iq.o_is_valid[1];
        iq.o_set2.o_valid = iq.o_is_valid[0];
        iq.o_full         = full;
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: push/pop, fill, wrap, stall, flush, compaction, reset.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam logic [IQ_PTR_W-1:0] WRAP_HEAD = IQ_PTR_W'(IQ_DEPTH - 1);

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    issue_queue_if iq();

    issue_queue #(.DEPTH(IQ_DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .iq   (iq)
    );

    always #5 clk = ~clk;

    function automatic PC_set make_set(input logic [31:0] pc);
        PC_set s;
        s.pc      = pc;
        s.inst    = ~pc;
        s.o_valid = 1'b1;
        return s;
    endfunction

    task automatic apply_stimulus(input logic [1:0] valid, input logic [31:0] pc1,
                                  input logic [31:0] pc2, input logic [1:0] using_num,
                                  input logic stall, input logic flush);
        iq.i_valid    = valid;
        iq.i_set1     = make_set(pc1);
        iq.i_set2     = make_set(pc2);
        iq.i_usingNUM = using_num;
        iq.stall      = stall;
        iq.flush      = flush;
    endtask

    // One clock with the given inputs, then the bus returns to idle for sampling.
    task automatic run_cycle(input logic [1:0] valid, input logic [31:0] pc1,
                             input logic [31:0] pc2, input logic [1:0] using_num,
                             input logic stall, input logic flush);
        apply_stimulus(valid, pc1, pc2, using_num, stall, flush);
        @(posedge clk);
        #1;
        apply_stimulus(2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        apply_stimulus(2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_full",     iq.o_full, 0);
        check_output("reset_is_valid", iq.o_is_valid, 0);
        check_output("reset_set1_v",   iq.o_set1.o_valid, 0);
        check_output("reset_set2_v",   iq.o_set2.o_valid, 0);
        rstn = 1'b1;

        // Push pair right after reset release
        run_cycle(2'b11, 32'h100, 32'h104, 2'd0, 1'b0, 1'b0);
        check_output("pair_is_valid", iq.o_is_valid, 2'b11);
        check_output("pair_set1_pc",  iq.o_set1.pc, 32'h100);
        check_output("pair_set2_pc",  iq.o_set2.pc, 32'h104);
        check_output("pair_set1_inst", iq.o_set1.inst, ~32'h100);

        // Fill to full
        run_cycle(2'b11, 32'h108, 32'h10c, 2'd0, 1'b0, 1'b0);
        run_cycle(2'b11, 32'h110, 32'h114, 2'd0, 1'b0, 1'b0);
        check_output("fill6_count", dut.count, 6);
        check_output("fill6_full",  iq.o_full, 0);
        run_cycle(2'b11, 32'h118, 32'h11c, 2'd0, 1'b0, 1'b0);
        check_output("fill8_count", dut.count, 8);
        check_output("fill8_full",  iq.o_full, 1);
        run_cycle(2'b11, 32'h200, 32'h204, 2'd0, 1'b0, 1'b0);
        check_output("drop_count", dut.count, 8);
        check_output("drop_set1",  iq.o_set1.pc, 32'h100);
        check_output("drop_tail",  dut.tail, 0);

        // Drain in pairs; the dropped pair must never surface
        run_cycle(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        check_output("drain1_full", iq.o_full, 0);
        check_output("drain1_set1", iq.o_set1.pc, 32'h108);
        check_output("drain1_set2", iq.o_set2.pc, 32'h10c);
        run_cycle(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        check_output("drain2_set1", iq.o_set1.pc, 32'h110);
        check_output("drain2_set2", iq.o_set2.pc, 32'h114);
        run_cycle(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        check_output("drain3_set1", iq.o_set1.pc, 32'h118);
        check_output("drain3_set2", iq.o_set2.pc, 32'h11c);
        run_cycle(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        check_output("drain4_count",    dut.count, 0);
        check_output("drain4_is_valid", iq.o_is_valid, 2'b00);

        // Seven entries, single pops up to head = 7, then a wrapping pair
        run_cycle(2'b11, 32'h300, 32'h301, 2'd0, 1'b0, 1'b0);
        run_cycle(2'b11, 32'h302, 32'h303, 2'd0, 1'b0, 1'b0);
        run_cycle(2'b11, 32'h304, 32'h305, 2'd0, 1'b0, 1'b0);
        run_cycle(2'b10, 32'h306, 32'h3ff, 2'd0, 1'b0, 1'b0);
        check_output("seven_count", dut.count, 7);
        run_cycle(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
        check_output("pop1_set1", iq.o_set1.pc, 32'h301);
        for (int i = 0; i < 6; i++) begin
            run_cycle(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
        end
        check_output("wrap_head",  dut.head, 32'(WRAP_HEAD));
        check_output("wrap_empty", iq.o_is_valid, 2'b00);
        run_cycle(2'b11, 32'h400, 32'h404, 2'd0, 1'b0, 1'b0);
        check_output("wrap_mem7",  dut.mem[7].pc, 32'h400);
        check_output("wrap_mem0",  dut.mem[0].pc, 32'h404);
        check_output("wrap_set1",  iq.o_set1.pc, 32'h400);
        check_output("wrap_set2",  iq.o_set2.pc, 32'h404);
        run_cycle(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        check_output("wrap_pop_count", dut.count, 0);
        check_output("wrap_pop_head",  dut.head, 1);

        // Simultaneous push/pop, without then with stall
        run_cycle(2'b11, 32'h500, 32'h501, 2'd0, 1'b0, 1'b0);
        run_cycle(2'b10, 32'h502, 32'h5ff, 2'd0, 1'b0, 1'b0);
        check_output("pp_start_count", dut.count, 3);
        run_cycle(2'b11, 32'h510, 32'h511, 2'd2, 1'b0, 1'b0);
        check_output("pp_nostall_count", dut.count, 3);
        check_output("pp_nostall_set1",  iq.o_set1.pc, 32'h502);
        check_output("pp_nostall_set2",  iq.o_set2.pc, 32'h510);
        run_cycle(2'b11, 32'h520, 32'h521, 2'd2, 1'b1, 1'b0);
        check_output("pp_stall_count", dut.count, 5);
        check_output("pp_stall_set1",  iq.o_set1.pc, 32'h502);

        // Flush beats stall, push and pop
        run_cycle(2'b11, 32'h600, 32'h601, 2'd1, 1'b1, 1'b1);
        check_output("flush_count",    dut.count, 0);
        check_output("flush_is_valid", iq.o_is_valid, 2'b00);
        check_output("flush_full",     iq.o_full, 0);
        check_output("flush_head",     dut.head, 0);

        // Compaction of a lone younger input, then clamped pop
        run_cycle(2'b01, 32'h700, 32'h704, 2'd0, 1'b0, 1'b0);
        check_output("compact_set1",     iq.o_set1.pc, 32'h704);
        check_output("compact_is_valid", iq.o_is_valid, 2'b10);
        check_output("compact_set2_v",   iq.o_set2.o_valid, 0);
        run_cycle(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        check_output("clamp_count", dut.count, 0);
        check_output("clamp_head",  dut.head, 1);

        // usingNUM = 3 never pops
        run_cycle(2'b11, 32'h800, 32'h804, 2'd3, 1'b0, 1'b0);
        check_output("use3_push_count", dut.count, 2);
        run_cycle(2'b00, 32'h0, 32'h0, 2'd3, 1'b0, 1'b0);
        check_output("use3_hold_count", dut.count, 2);
        check_output("use3_set1",       iq.o_set1.pc, 32'h800);

        // Asynchronous reset mid-cycle, then push in the first cycle after release
        #2;
        rstn = 1'b0;
        #1;
        check_output("async_rst_count",    dut.count, 0);
        check_output("async_rst_is_valid", iq.o_is_valid, 2'b00);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run_cycle(2'b11, 32'ha00, 32'ha04, 2'd0, 1'b0, 1'b0);
        check_output("post_rst_count", dut.count, 2);
        check_output("post_rst_set1",  iq.o_set1.pc, 32'ha00);
        check_output("post_rst_set2",  iq.o_set2.pc, 32'ha04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
